// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Debounces one mechanical push-button. The pin goes through a
//             two-flop synchronizer and is normalized so that 1 = pressed. A
//             four-state FSM accepts a level change only after DEBOUNCE_CYCLES
//             consecutive agreeing samples. The FSM produces a debounced level,
//             press/release strobes, and a long-press strobe plus a level flag.
//  Ports    :
//    clk           in   system clock
//    reset_n       in   asynchronous active-low reset
//    en            in   synchronous enable; low holds detection off
//    key_raw       in   asynchronous, bouncing button pin
//    key_level     out  debounced state, 1 = pressed
//    press_pulse   out  one-cycle strobe on confirmed press
//    release_pulse out  one-cycle strobe on confirmed release
//    long_pulse    out  one-cycle strobe when a press reaches LONG_CYCLES
//    long_flag     out  high from long_pulse until confirmed release
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic long_flag
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LG_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [DB_W-1:0] c_db_last  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] c_db_one   = DB_W'(1);
    localparam logic [LG_W-1:0] c_lg_last  = LG_W'(LONG_CYCLES - 1);
    localparam logic [LG_W-1:0] c_lg_max   = LG_W'(LONG_CYCLES);
    // Raw pin level of an untouched button.
    localparam logic            c_idle_lvl = ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_cnt;
    logic [LG_W-1:0]   r_hold;

    logic              w_p_sync;
    logic              w_hold_hit;
    logic [LG_W-1:0]   w_hold_inc;

    // ------------------------------------------------------------------
    // Synchronizer. It resets to the not-pressed level so that a key held
    // through reset still needs full qualification afterwards. It keeps
    // running while en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= c_idle_lvl;
            r_sync2 <= c_idle_lvl;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p_sync = r_sync2 ^ ACTIVE_LOW;

    // Hold counter saturates at LONG_CYCLES. Because the threshold is hit
    // on exactly one increment, the long-press strobe fires once per press.
    assign w_hold_hit = (r_hold == c_lg_last);
    assign w_hold_inc = (r_hold == c_lg_max) ? r_hold : r_hold + 1'b1;

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hold        <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            long_flag     <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            if (!en) begin
                // Forced quiet. A held key is dropped without a release strobe.
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_hold    <= '0;
                key_level <= 1'b0;
                long_flag <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (w_p_sync) begin
                            r_state <= S_PRESS_WAIT;
                            r_cnt   <= c_db_one;
                        end
                    end

                    S_PRESS_WAIT: begin
                        if (!w_p_sync) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_db_last) begin
                            r_state     <= S_PRESSED;
                            r_cnt       <= '0;
                            r_hold      <= '0;
                            key_level   <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    S_PRESSED: begin
                        r_hold <= w_hold_inc;
                        if (w_hold_hit) begin
                            long_pulse <= 1'b1;
                            long_flag  <= 1'b1;
                        end
                        if (!w_p_sync) begin
                            r_state <= S_RELEASE_WAIT;
                            r_cnt   <= c_db_one;
                        end
                    end

                    S_RELEASE_WAIT: begin
                        if (!w_p_sync && (r_cnt == c_db_last)) begin
                            // Confirmed release. It takes priority over a
                            // long-press threshold landing on the same edge.
                            r_state       <= S_IDLE;
                            r_cnt         <= '0;
                            r_hold        <= '0;
                            key_level     <= 1'b0;
                            release_pulse <= 1'b1;
                            long_flag     <= 1'b0;
                        end else begin
                            // The press is still alive (bounce-back or still
                            // qualifying), so the hold time keeps accumulating.
                            r_hold <= w_hold_inc;
                            if (w_hold_hit) begin
                                long_pulse <= 1'b1;
                                long_flag  <= 1'b1;
                            end
                            if (w_p_sync) begin
                                r_state <= S_PRESSED;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_hold  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce
//  Purpose  : Self-checking bench for key_debounce (DEBOUNCE_CYCLES=4,
//             LONG_CYCLES=16, ACTIVE_LOW=1). A run-length behavioural model
//             is compared against the DUT on every falling edge. Directed
//             scenarios also pin exact strobe edges with literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_debounce;

    localparam int D = 4;
    localparam int L = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b1;
    logic key_raw = 1'b1;
    logic key_level, press_pulse, release_pulse, long_pulse, long_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_flag     (long_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The synchronizer is a two-deep raw-sample history.
    // The debounced level flips once D consecutive samples disagree with it.
    // The press age counts edges since the confirmed press, and long-press
    // fires when that age reaches L, unless the press ends on that edge.
    // ------------------------------------------------------------------
    bit m_s1 = 1'b1, m_s2 = 1'b1;
    bit m_p, m_hit;
    bit m_level, m_press, m_rel, m_long, m_lflag;
    int m_run, m_age;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_run = 0; m_age = 0;
            m_level = 0; m_press = 0; m_rel = 0; m_long = 0; m_lflag = 0;
        end else begin
            m_p  = !m_s2;
            m_s2 = m_s1;
            m_s1 = key_raw;
            m_press = 0; m_rel = 0; m_long = 0;
            if (!en) begin
                m_run = 0; m_age = 0; m_level = 0; m_lflag = 0;
            end else begin
                m_hit = m_level && (m_age == L - 1);
                if (m_level && m_age < L) m_age++;
                if (m_p != m_level) m_run++;
                else                m_run = 0;
                if (m_run == D) begin
                    m_run   = 0;
                    m_level = m_p;
                    m_age   = 0;
                    if (m_p) m_press = 1;
                    else begin
                        m_rel   = 1;
                        m_lflag = 0;
                    end
                end else if (m_hit) begin
                    m_long  = 1;
                    m_lflag = 1;
                end
            end
        end
    end

    // Every-cycle comparison and strobe tallies, away from the active edge.
    always @(negedge clk) begin
        check("level",   key_level,     m_level);
        check("press",   press_pulse,   m_press);
        check("release", release_pulse, m_rel);
        check("long",    long_pulse,    m_long);
        check("lflag",   long_flag,     m_lflag);
        check("press_and_release_exclusive", press_pulse && release_pulse, 1'b0);
        if (press_pulse)   n_press++;
        if (release_pulse) n_rel++;
        if (long_pulse)    n_long++;
    end

    // Advance to 2 time units after the next rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int p0, r0, l0;

    initial begin
        // Reset state
        step(2);
        check("rst_level", key_level, 1'b0);
        check("rst_press", press_pulse, 1'b0);
        check("rst_lflag", long_flag, 1'b0);
        reset_n = 1'b1;
        step(3);

        // Clean press: strobe on edge 6, long-press 16 edges later
        key_raw = 1'b0;
        step(5);
        check("clean_e5_level", key_level, 1'b0);
        check("clean_e5_press", press_pulse, 1'b0);
        step(1);
        check("clean_e6_press", press_pulse, 1'b1);
        check("clean_e6_level", key_level, 1'b1);
        step(1);
        check("clean_e7_press", press_pulse, 1'b0);
        step(14);
        check("clean_long_early", long_pulse, 1'b0);
        step(1);
        check("clean_long", long_pulse, 1'b1);
        check("clean_lflag", long_flag, 1'b1);
        step(1);
        check("clean_long_off", long_pulse, 1'b0);
        check("clean_lflag_hold", long_flag, 1'b1);
        step(7);

        // Release: strobe on edge 6, flag cleared on the same edge
        key_raw = 1'b1;
        step(5);
        check("rel_e5_level", key_level, 1'b1);
        check("rel_e5_rel", release_pulse, 1'b0);
        step(1);
        check("rel_e6_rel", release_pulse, 1'b1);
        check("rel_e6_level", key_level, 1'b0);
        check("rel_e6_lflag", long_flag, 1'b0);
        step(4);

        // Bounce: toggling every 2 cycles never qualifies
        p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 10; i++) begin
            key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        key_raw = 1'b1;
        step(10);
        check("bounce_level", key_level, 1'b0);
        check_int("bounce_press_cnt", n_press - p0, 0);
        check_int("bounce_rel_cnt", n_rel - r0, 0);

        // Release glitch: 2-cycle high pulse while pressed
        p0 = n_press; r0 = n_rel; l0 = n_long;
        key_raw = 1'b0;
        step(6);
        check("glitch_press", press_pulse, 1'b1);
        key_raw = 1'b1;
        step(2);
        key_raw = 1'b0;
        step(10);
        check("glitch_level", key_level, 1'b1);
        check_int("glitch_press_cnt", n_press - p0, 1);
        check_int("glitch_rel_cnt", n_rel - r0, 0);
        // Bounce-back keeps the hold age: long still 16 edges after press
        step(3);
        check("glitch_long_early", long_pulse, 1'b0);
        step(1);
        check("glitch_long", long_pulse, 1'b1);
        step(20);
        check_int("glitch_long_once", n_long - l0, 1);

        // en drop while pressed
        r0 = n_rel;
        en = 1'b0;
        step(1);
        check("en_level", key_level, 1'b0);
        check("en_lflag", long_flag, 1'b0);
        check("en_rel", release_pulse, 1'b0);
        step(3);
        check_int("en_rel_cnt", n_rel - r0, 0);
        en = 1'b1;
        step(3);
        check("en_e3_press", press_pulse, 1'b0);
        step(1);
        check("en_e4_press", press_pulse, 1'b1);
        key_raw = 1'b1;
        step(8);

        // Async reset while pressed clears outputs without a clock edge
        key_raw = 1'b0;
        step(6);
        check("ar_pressed", key_level, 1'b1);
        reset_n = 1'b0;
        #1;
        check("ar_level_now", key_level, 1'b0);
        step(2);
        reset_n = 1'b1;
        step(5);
        check("ar_e5_level", key_level, 1'b0);
        step(1);
        check("ar_e6_press", press_pulse, 1'b1);
        key_raw = 1'b1;
        step(8);

        // Async reset mid-PRESS_WAIT, then full latency again
        key_raw = 1'b0;
        step(4);
        reset_n = 1'b0;
        #1;
        check("pw_rst_level", key_level, 1'b0);
        step(1);
        reset_n = 1'b1;
        step(5);
        check("pw_e5_press", press_pulse, 1'b0);
        step(1);
        check("pw_e6_press", press_pulse, 1'b1);
        check("pw_e6_level", key_level, 1'b1);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
